lstm_input_fetcher: RTL
=======================

Name: lstm_input_fetcher

Overview:
Sequences reads from the byte-wide, combinational-read input data memory (16-bit address, 8-bit data). It streams per-timestep input frames to the LSTM datapath. It walks a configured base address across a number of frames and packs consecutive bytes into PACK-byte beats. Beats leave through a 2-entry valid/ready output FIFO, with frame and sequence boundary flags. It sits between the input memory and the LSTM gate-compute core and is the only master of the memory address bus.

Parameters:
ADDR_W, 16, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, memory byte width
PACK, 4, bytes per output beat; output width PACK*DATA_W
FRAME_LEN, 64, bytes per timestep frame; must be a nonzero multiple of PACK (elaboration check)
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_base and cfg_num_frames when idle
abort  in  1  synchronous cancel of the current run
cfg_base  in  ADDR_W  first byte address
cfg_num_frames  in  CNT_W  number of frames to fetch
mem_addr  out  ADDR_W  address to input memory (registered)
mem_data  in  DATA_W  memory read data, valid combinationally for current mem_addr
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
out_data  out  PACK*DATA_W  packed beat; byte k of beat in bits [8k+7:8k], byte 0 = lowest address
out_frame_last  out  1  beat is last of its frame
out_seq_last  out  1  beat is last of the run
busy  out  1  high from the cycle after accepted start until done or abort
done  out  1  one-cycle pulse after final beat handshake

Behaviour:
- Reset: state IDLE; mem_addr=0; out_valid=0; out_data=0; out_frame_last=0; out_seq_last=0; busy=0; done=0; FIFO empty; pack count=0.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start with cfg_num_frames>0 -> FETCH; mem_addr<=cfg_base; byte/frame counters cleared.
  - start with cfg_num_frames==0 -> DONE directly, no reads.
  - start is ignored in any other state.
- FETCH, per cycle:
  - A byte is captured when pack is not full, or when a full pack is pushed this cycle.
  - On capture: mem_data is written into pack slot [pack_cnt]; mem_addr increments (wraps FFFF->0000); byte_in_frame increments.
  - A full pack is pushed into the FIFO when the FIFO is not full, or when it is being popped this cycle.
  - The push carries frame_last=(frame's final beat) and seq_last=(final beat of final frame).
  - After the last byte of the last frame is captured -> DRAIN.
- DRAIN: pushes any remaining pack. When the FIFO is empty and the last beat's handshake has completed -> DONE.
- DONE: done=1 for exactly one cycle; busy=0 from that cycle on; -> IDLE.
- Latency: the first beat is visible (out_valid=1) PACK+1 cycles after the start pulse, with out_ready held high. Steady-state throughput is 1 byte/cycle (one beat per PACK cycles).
- Output FIFO, 2 entries:
  - out_* come directly from the head register.
  - Push and pop in the same cycle while full is legal.
  - out_data and flags stay stable while out_valid=1 and out_ready=0.
- Backpressure: with the FIFO full and the pack full, mem_addr freezes and no byte is captured. At most 2*PACK+PACK bytes are buffered in flight.
- abort, any state:
  - Next cycle: IDLE; FIFO flushed; out_valid=0; pack cleared; busy=0; no done pulse; mem_addr holds its value.
  - abort has priority over start in the same cycle.
- Reset mid-run has the same effect as abort, and additionally applies the reset values above.
- Counters do not overflow: frame_cnt compares to the latched cfg_num_frames. byte_in_frame wraps at FRAME_LEN.

Decomposition:
- Shared package lstm_fetch_pkg holds:
  - state enum {IDLE, FETCH, DRAIN, DONE};
  - localparams BEAT_W=PACK*DATA_W, BEATS_PER_FRAME=FRAME_LEN/PACK;
  - beat struct {data, frame_last, seq_last}.
- One natural sub-module: fetch_out_fifo2, a 2-entry valid/ready FIFO carrying the beat struct.

Test Plan:
- Preloaded memory; start, cfg_base=0x0000, cfg_num_frames=1, out_ready=1 -> 16 beats of 0x80808080; out_frame_last and out_seq_last only on beat 16; done pulses once; mem_addr ends at 0x0040.
- cfg_base=0x0040, cfg_num_frames=2 (bytes 0x40-0xBF) -> beat 1=0x5DCD4F59, beat 2=0x6F5C1616, beat 17=0xD930BD08; frame_last on beats 16 and 32; seq_last only on 32.
- Same run with out_ready low for 10 cycles after the first beat -> out_data holds 0x5DCD4F59; mem_addr freezes once FIFO and pack are full; no byte lost or duplicated; beat sequence identical to the unstalled run.
- start with cfg_num_frames=0 -> done one cycle later; out_valid never high; mem_addr unchanged.
- cfg_base=0xFFFE, 1 frame -> first beat = {mem[0x0001], mem[0x0000], mem[0xFFFF], mem[0xFFFE]}; mem_addr wraps correctly.
- abort asserted at beat 5 of a 2-frame run, then a new start -> out_valid drops next cycle; no done pulse; the second run starts cleanly from its own cfg_base.

Source files
------------

// File: rtl/lstm_fetch_pkg.sv
// Shared types and geometry for the LSTM input fetcher and its output FIFO.
package lstm_fetch_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_PACK      = 4;
  localparam int DEF_FRAME_LEN = 64;
  localparam int DEF_CNT_W     = 16;

  localparam int BEAT_W          = DEF_PACK * DEF_DATA_W;
  localparam int BEATS_PER_FRAME = DEF_FRAME_LEN / DEF_PACK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One packed output beat plus its boundary flags.
  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic              frame_last;
    logic              seq_last;
  } beat_t;

endpackage

// File: rtl/lstm_input_fetcher_fifo.sv
// Two-entry valid/ready FIFO for packed beats; the head register drives the outputs.
module fetch_out_fifo2
  import lstm_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       push_i,
  input  beat_t      push_beat_i,
  output logic       in_ready_o,
  output logic       valid_o,
  input  logic       ready_i,
  output beat_t      head_o,
  output logic [1:0] count_o
);

  beat_t      head_q;
  beat_t      tail_q;
  logic [1:0] count_q;
  logic       pop;
  logic       do_push;

  assign pop        = ready_i && (count_q != 2'd0);
  // A full FIFO still accepts a push in the cycle its head is popped.
  assign in_ready_o = (count_q != 2'd2) || pop;
  assign do_push    = push_i && in_ready_o;

  assign valid_o = (count_q != 2'd0);
  assign head_o  = head_q;
  assign count_o = count_q;

  // Head/tail shuffle for every push/pop combination; flush empties without touching data.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      unique case ({do_push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_beat_i;
          else                 tail_q <= push_beat_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_beat_i;
          end else begin
            head_q <= push_beat_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lstm_input_fetcher.sv
// Walks the input memory from a base address over N frames, packs bytes into
// beats and streams them with frame/sequence boundary flags.
module lstm_input_fetcher
  import lstm_fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PACK      = DEF_PACK,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [CNT_W-1:0]       cfg_num_frames,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PACK*DATA_W-1:0] out_data,
  output logic                   out_frame_last,
  output logic                   out_seq_last,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = $clog2(PACK);
  localparam int PC_W  = $clog2(PACK + 1);
  localparam int BIF_W = $clog2(FRAME_LEN);

  // Frames must hold whole beats, and the beat struct width is fixed by the package.
  if (FRAME_LEN == 0 || (FRAME_LEN % PACK) != 0 || PACK < 2 ||
      PACK * DATA_W != BEAT_W || FRAME_LEN != BEATS_PER_FRAME * PACK) begin : g_bad_geometry
    $error("lstm_input_fetcher: FRAME_LEN must be a nonzero multiple of PACK matching lstm_fetch_pkg");
  end

  state_e                       state_q;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]             num_frames_q;
  logic [CNT_W-1:0]             frame_cnt_q, frame_cnt_d;
  logic [BIF_W-1:0]             byte_in_frame_q, byte_in_frame_d;
  logic [PC_W-1:0]              pack_cnt_q, pack_cnt_d;
  logic [PACK-1:0][DATA_W-1:0]  pack_q;
  logic                         pack_frame_last_q;
  logic                         pack_seq_last_q;
  logic                         busy_q;
  logic                         done_q;

  logic                         active;
  logic                         pack_full;
  logic                         push;
  logic                         capture;
  logic                         frame_end;
  logic                         last_byte;
  logic                         pop;
  logic                         drain_done;
  logic [IDX_W-1:0]             slot;

  logic                         fifo_in_ready;
  logic                         fifo_valid;
  logic [1:0]                   fifo_count;
  beat_t                        push_beat;
  beat_t                        head_beat;

  assign active    = (state_q == FETCH) || (state_q == DRAIN);
  assign pack_full = (pack_cnt_q == PC_W'(PACK));
  assign push      = active && pack_full && fifo_in_ready;
  // A byte enters the pack when there is room, or when the full pack leaves this cycle.
  assign capture   = (state_q == FETCH) && (!pack_full || push);
  assign slot      = push ? '0 : pack_cnt_q[IDX_W-1:0];
  assign frame_end = (byte_in_frame_q == BIF_W'(FRAME_LEN - 1));
  assign last_byte = frame_end && (frame_cnt_q == num_frames_q - CNT_W'(1));
  assign pop       = fifo_valid && out_ready;
  // The run is finished once the pack is empty and the FIFO empties this cycle.
  assign drain_done = !pack_full &&
                      ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  assign push_beat = '{data: pack_q, frame_last: pack_frame_last_q, seq_last: pack_seq_last_q};

  // Next address, frame position and pack fill for the capture/push of this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned (which would infer a latch); blocking '=' is right for combinational logic.
    mem_addr_d      = mem_addr_q;
    frame_cnt_d     = frame_cnt_q;
    byte_in_frame_d = byte_in_frame_q;
    pack_cnt_d      = pack_cnt_q;
    if (push) pack_cnt_d = '0;
    if (capture) begin
      mem_addr_d = mem_addr_q + ADDR_W'(1);
      pack_cnt_d = pack_cnt_d + PC_W'(1);
      if (frame_end) begin
        byte_in_frame_d = '0;
        frame_cnt_d     = frame_cnt_q + CNT_W'(1);
      end else begin
        byte_in_frame_d = byte_in_frame_q + BIF_W'(1);
      end
    end
  end

  // Control FSM with counters and registered status outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update from
    // the same pre-edge values.
    if (rst) begin
      state_q           <= IDLE;
      mem_addr_q        <= '0;
      num_frames_q      <= '0;
      frame_cnt_q       <= '0;
      byte_in_frame_q   <= '0;
      pack_cnt_q        <= '0;
      pack_frame_last_q <= 1'b0;
      pack_seq_last_q   <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else if (abort) begin
      state_q    <= IDLE;
      pack_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      mem_addr_q      <= mem_addr_d;
      frame_cnt_q     <= frame_cnt_d;
      byte_in_frame_q <= byte_in_frame_d;
      pack_cnt_q      <= pack_cnt_d;
      if (capture && (slot == IDX_W'(PACK - 1))) begin
        pack_frame_last_q <= frame_end;
        pack_seq_last_q   <= last_byte;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            num_frames_q    <= cfg_num_frames;
            frame_cnt_q     <= '0;
            byte_in_frame_q <= '0;
            pack_cnt_q      <= '0;
            if (cfg_num_frames != '0) begin
              mem_addr_q <= cfg_base;
              busy_q     <= 1'b1;
              state_q    <= FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        FETCH: begin
          if (capture && last_byte) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte slots of the pack being assembled.
  always_ff @(posedge clk) begin
    // NOTE: pack storage has no reset; pack_cnt_q alone says which slots hold live data.
    if (capture) pack_q[slot] <= mem_data;
  end

  fetch_out_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (abort),
    .push_i      (push),
    .push_beat_i (push_beat),
    .in_ready_o  (fifo_in_ready),
    .valid_o     (fifo_valid),
    .ready_i     (out_ready),
    .head_o      (head_beat),
    .count_o     (fifo_count)
  );

  assign mem_addr       = mem_addr_q;
  assign out_valid      = fifo_valid;
  assign out_data       = head_beat.data;
  assign out_frame_last = head_beat.frame_last;
  assign out_seq_last   = head_beat.seq_last;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
